// File: rtl/display_decoder.sv
// Signed binary to three-digit seven-segment display stage with sign digit.
// Magnitude is converted by a fixed 10-iteration shift-add-3 engine.
module display_decoder #(
    parameter int unsigned WIDTH = 32
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             load,
    input  logic [WIDTH-1:0] value,
    output logic [6:0]       OUT_H,
    output logic [6:0]       OUT_T,
    output logic [6:0]       OUT_O,
    output logic [6:0]       OUT_N,
    output logic             busy,
    output logic             done
);

    localparam logic [6:0] SegBlank = 7'b1111111;
    localparam logic [6:0] SegMinus = 7'b0111111;
    localparam logic [6:0] SegE     = 7'b0000110;
    localparam logic [6:0] SegR     = 7'b0101111;

    typedef enum logic [1:0] {StIdle, StConvert, StUpdate} state_e;

    state_e     state_q, state_d;
    logic       sign_q, sign_d;
    logic       ovf_q, ovf_d;
    logic [9:0] shift_q, shift_d;
    logic [3:0] hund_q, hund_d;
    logic [3:0] tens_q, tens_d;
    logic [3:0] ones_q, ones_d;
    logic [3:0] cnt_q, cnt_d;
    logic [6:0] out_h_q, out_h_d;
    logic [6:0] out_t_q, out_t_d;
    logic [6:0] out_o_q, out_o_d;
    logic [6:0] out_n_q, out_n_d;
    logic       done_q, done_d;

    logic [WIDTH-1:0] mag;
    logic [21:0]      dabble;

    function automatic logic [3:0] add3(input logic [3:0] d);
        return (d >= 4'd5) ? d + 4'd3 : d;
    endfunction

    function automatic logic [6:0] seg(input logic [3:0] d);
        logic [6:0] s;
        case (d)
            4'd0:    s = 7'b1000000;
            4'd1:    s = 7'b1111001;
            4'd2:    s = 7'b0100100;
            4'd3:    s = 7'b0110000;
            4'd4:    s = 7'b0011001;
            4'd5:    s = 7'b0010010;
            4'd6:    s = 7'b0000010;
            4'd7:    s = 7'b1111000;
            4'd8:    s = 7'b0000000;
            4'd9:    s = 7'b0010000;
            default: s = SegBlank;
        endcase
        return s;
    endfunction

    // Unsigned negate so the most negative input maps to 2^(WIDTH-1).
    assign mag    = value[WIDTH-1] ? (~value + 1'b1) : value;
    assign dabble = {add3(hund_q), add3(tens_q), add3(ones_q), shift_q} << 1;

    always_comb begin
        state_d = state_q;
        sign_d  = sign_q;
        ovf_d   = ovf_q;
        shift_d = shift_q;
        hund_d  = hund_q;
        tens_d  = tens_q;
        ones_d  = ones_q;
        cnt_d   = cnt_q;
        out_h_d = out_h_q;
        out_t_d = out_t_q;
        out_o_d = out_o_q;
        out_n_d = out_n_q;
        done_d  = 1'b0;
        case (state_q)
            StIdle: begin
                if (load) begin
                    sign_d  = value[WIDTH-1];
                    ovf_d   = (mag > WIDTH'(999));
                    shift_d = mag[9:0];
                    hund_d  = 4'd0;
                    tens_d  = 4'd0;
                    ones_d  = 4'd0;
                    cnt_d   = 4'd0;
                    state_d = StConvert;
                end
            end
            StConvert: begin
                {hund_d, tens_d, ones_d, shift_d} = dabble;
                cnt_d = cnt_q + 4'd1;
                if (cnt_q == 4'd9) begin
                    state_d = StUpdate;
                end
            end
            StUpdate: begin
                if (ovf_q) begin
                    out_h_d = SegE;
                    out_t_d = SegR;
                    out_o_d = SegR;
                end else begin
                    out_h_d = (hund_q == 4'd0) ? SegBlank : seg(hund_q);
                    out_t_d = (hund_q == 4'd0 && tens_q == 4'd0) ? SegBlank : seg(tens_q);
                    out_o_d = seg(ones_q);
                end
                out_n_d = sign_q ? SegMinus : SegBlank;
                done_d  = 1'b1;
                state_d = StIdle;
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q <= StIdle;
            sign_q  <= 1'b0;
            ovf_q   <= 1'b0;
            shift_q <= '0;
            hund_q  <= '0;
            tens_q  <= '0;
            ones_q  <= '0;
            cnt_q   <= '0;
            out_h_q <= SegBlank;
            out_t_q <= SegBlank;
            out_o_q <= SegBlank;
            out_n_q <= SegBlank;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            sign_q  <= sign_d;
            ovf_q   <= ovf_d;
            shift_q <= shift_d;
            hund_q  <= hund_d;
            tens_q  <= tens_d;
            ones_q  <= ones_d;
            cnt_q   <= cnt_d;
            out_h_q <= out_h_d;
            out_t_q <= out_t_d;
            out_o_q <= out_o_d;
            out_n_q <= out_n_d;
            done_q  <= done_d;
        end
    end

    assign OUT_H = out_h_q;
    assign OUT_T = out_t_q;
    assign OUT_O = out_o_q;
    assign OUT_N = out_n_q;
    assign busy  = (state_q != StIdle);
    assign done  = done_q;

endmodule

// File: tb/tb_display_decoder.sv
// Directed bench for display_decoder: expected displays are queued when a load
// is accepted and compared when done pulses.
module tb_display_decoder;

    localparam logic [6:0] BLANK = 7'b1111111;
    localparam logic [6:0] MINUS = 7'b0111111;
    localparam logic [6:0] LET_E = 7'b0000110;
    localparam logic [6:0] LET_R = 7'b0101111;

    typedef struct packed {
        logic [6:0] h;
        logic [6:0] t;
        logic [6:0] o;
        logic [6:0] n;
    } disp_t;

    logic        clock = 1'b0;
    logic        reset = 1'b0;
    logic        load  = 1'b0;
    logic [31:0] value = '0;
    logic [6:0]  out_h, out_t, out_o, out_n;
    logic        busy, done;

    int checks   = 0;
    int failures = 0;

    logic [6:0] seg_tab [0:9] = '{7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000, 7'b0011001,
                                  7'b0010010, 7'b0000010, 7'b1111000, 7'b0000000, 7'b0010000};
    disp_t sb[$];

    display_decoder #(.WIDTH(32)) dut (
        .clock (clock),
        .reset (reset),
        .load  (load),
        .value (value),
        .OUT_H (out_h),
        .OUT_T (out_t),
        .OUT_O (out_o),
        .OUT_N (out_n),
        .busy  (busy),
        .done  (done)
    );

    always #5 clock = ~clock;

    function automatic disp_t model(input logic [31:0] v);
        longint sv, mag;
        int h, t, o;
        disp_t r;
        sv  = longint'($signed(v));
        mag = (sv < 0) ? -sv : sv;
        r.n = (sv < 0) ? MINUS : BLANK;
        if (mag > 999) begin
            r.h = LET_E;
            r.t = LET_R;
            r.o = LET_R;
        end else begin
            h = int'(mag / 100);
            t = int'((mag / 10) % 10);
            o = int'(mag % 10);
            r.h = (h == 0) ? BLANK : seg_tab[h];
            r.t = (h == 0 && t == 0) ? BLANK : seg_tab[t];
            r.o = seg_tab[o];
        end
        return r;
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic compare_front(input string tag);
        disp_t e;
        check({tag, "_sb_nonempty"}, 32'(sb.size() > 0), 32'd1);
        if (sb.size() > 0) begin
            e = sb.pop_front();
            check({tag, "_h"}, 32'(out_h), 32'(e.h));
            check({tag, "_t"}, 32'(out_t), 32'(e.t));
            check({tag, "_o"}, 32'(out_o), 32'(e.o));
            check({tag, "_n"}, 32'(out_n), 32'(e.n));
        end
    endtask

    // Called #1 after the accepting edge; done is expected exp_lat edges later.
    task automatic wait_done(input string tag, input int exp_lat);
        int k;
        k = 0;
        while (k < 20) begin
            @(posedge clock);
            #1;
            k++;
            if (done === 1'b1) break;
        end
        check({tag, "_latency"}, 32'(k), 32'(exp_lat));
        check({tag, "_busy_low"}, 32'(busy), 32'd0);
        compare_front(tag);
        @(posedge clock);
        #1;
        check({tag, "_done_pulse"}, 32'(done), 32'd0);
    endtask

    task automatic convert(input string tag, input logic [31:0] v);
        @(negedge clock);
        load  = 1'b1;
        value = v;
        @(posedge clock);
        #1;
        load  = 1'b0;
        value = $urandom();
        sb.push_back(model(v));
        check({tag, "_busy"}, 32'(busy), 32'd1);
        wait_done(tag, 11);
    endtask

    initial begin
        int dones;
        #12;
        check("rst_h", 32'(out_h), 32'(BLANK));
        check("rst_t", 32'(out_t), 32'(BLANK));
        check("rst_o", 32'(out_o), 32'(BLANK));
        check("rst_n", 32'(out_n), 32'(BLANK));
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_done", 32'(done), 32'd0);
        @(negedge clock);
        reset = 1'b1;

        convert("zero", 32'd0);
        convert("neg507", -32'sd507);
        convert("p42", 32'd42);
        convert("p999", 32'd999);
        convert("p1000", 32'd1000);
        convert("minint", 32'h8000_0000);
        convert("neg1", 32'hFFFF_FFFF);
        convert("p105", 32'd105);

        // Loads at E3 and E11 must be dropped; the one at E12 is taken.
        @(negedge clock);
        load  = 1'b1;
        value = 32'd123;
        @(posedge clock);
        #1;
        load = 1'b0;
        sb.push_back(model(32'd123));
        for (int e = 1; e <= 23; e++) begin
            @(negedge clock);
            load  = (e == 3 || e == 11 || e == 12);
            value = (e == 12) ? -32'sd8 : $urandom();
            @(posedge clock);
            #1;
            if (e == 12) sb.push_back(model(-32'sd8));
            check($sformatf("ign_done_e%0d", e), 32'(done), 32'(e == 11 || e == 23));
            if (done === 1'b1) compare_front($sformatf("ign_e%0d", e));
        end
        load = 1'b0;
        check("ign_sb_empty", 32'(sb.size()), 32'd0);

        // Reset during CONVERT clears outputs asynchronously and drops the request.
        @(negedge clock);
        load  = 1'b1;
        value = 32'd555;
        @(posedge clock);
        #1;
        load = 1'b0;
        repeat (4) @(posedge clock);
        #1;
        reset = 1'b0;
        #1;
        check("mid_rst_h", 32'(out_h), 32'(BLANK));
        check("mid_rst_t", 32'(out_t), 32'(BLANK));
        check("mid_rst_o", 32'(out_o), 32'(BLANK));
        check("mid_rst_n", 32'(out_n), 32'(BLANK));
        check("mid_rst_busy", 32'(busy), 32'd0);
        check("mid_rst_done", 32'(done), 32'd0);
        @(negedge clock);
        reset = 1'b1;
        dones = 0;
        repeat (15) begin
            @(posedge clock);
            #1;
            if (done === 1'b1) dones++;
        end
        check("mid_rst_no_done", 32'(dones), 32'd0);
        check("mid_rst_idle", 32'(busy), 32'd0);

        // Load held through reset release is taken on the first clean edge.
        @(negedge clock);
        reset = 1'b0;
        load  = 1'b1;
        value = 32'd77;
        @(posedge clock);
        #1;
        check("coinc_held", 32'(busy), 32'd0);
        @(negedge clock);
        reset = 1'b1;
        @(posedge clock);
        #1;
        load = 1'b0;
        sb.push_back(model(32'd77));
        check("coinc_busy", 32'(busy), 32'd1);
        wait_done("coinc", 11);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/display_decoder.md
# display_decoder

Sequential binary-to-seven-segment stage directly downstream of the processor core. It captures a signed two's-complement result on a one-cycle `load` strobe and converts its magnitude to hundreds/tens/ones BCD with an iterative shift-add-3 (double-dabble) engine. It then drives the four board displays `OUT_H`, `OUT_T`, `OUT_O` and `OUT_N` (sign). Displayed values hold until the next completed conversion.

## Interface
- `WIDTH`, default 32: width of the signed input `value`; must be ≥ 11.
- `clock`  in  1: single system clock; all state updates on its rising edge.
- `reset`  in  1: asynchronous, active-low; clears all state immediately.
- `load`  in  1: request strobe; sampled only in IDLE.
- `value`  in  WIDTH: signed two's-complement number to display.
- `OUT_H`  out  7: hundreds digit, active-low segments, bit0=a … bit6=g.
- `OUT_T`  out  7: tens digit, same encoding.
- `OUT_O`  out  7: ones digit, same encoding.
- `OUT_N`  out  7: sign display, same encoding.
- `busy`  out  1: high from the cycle after `load` is accepted until `done`.
- `done`  out  1: one-cycle pulse when the outputs take a new value.

## Operation
- Reset values: `OUT_H`, `OUT_T`, `OUT_O` and `OUT_N` = 7'b1111111 (blank); `busy`=0; `done`=0; FSM in IDLE; digit and shift registers 0.
- FSM states: IDLE, CONVERT, UPDATE.
- IDLE with `load`=1:
  - register sign = `value[WIDTH-1]`;
  - register magnitude = sign ? −value : value (WIDTH-bit unsigned, so −2^(WIDTH−1) yields 2^(WIDTH−1));
  - register ovf = (magnitude > 999);
  - load the 10-bit shift register with magnitude[9:0];
  - clear BCD digits and the iteration counter;
  - go to CONVERT.
- IDLE with `load`=0: no change.
- CONVERT, one iteration per cycle:
  - first, add 3 to each BCD digit ≥ 5;
  - then shift {hundreds, tens, ones, shift} left by 1;
  - after the 10th iteration (counter 0..9), go to UPDATE.
- The conversion always runs 10 iterations, even when ovf=1, so latency is constant.
- UPDATE:
  - write all four outputs, assert `done` for this cycle, return to IDLE.
  - If ovf=0: show digit patterns with leading-zero suppression. `OUT_H` is blank when hundreds=0. `OUT_T` is blank when hundreds=0 and tens=0. `OUT_O` is always shown.
  - If ovf=1: `OUT_H`="E" (7'b0000110); `OUT_T`="r" (7'b0101111); `OUT_O`="r" (7'b0101111).
  - `OUT_N` = minus (7'b0111111) when sign=1, else blank. This applies for overflow too. Zero is never negative.
- Digit patterns 0–9 (active-low, g..a):
  - 0: 1000000; 1: 1111001; 2: 0100100; 3: 0110000; 4: 0011001
  - 5: 0010010; 6: 0000010; 7: 1111000; 8: 0000000; 9: 0010000
- `load` while in CONVERT or UPDATE is ignored and is not queued.
- `value` is only sampled on the accepting edge; changes afterwards have no effect.

## Timing
- Edge E0: `load`=1 sampled in IDLE. From E0, `busy`=1.
- Edges E1..E10: conversion iterations.
- Edge E11: outputs update, `done`=1 and `busy`=0.
- Edge E12: `done` returns to 0.
- A `load` held high at E11 is not accepted: the FSM is in UPDATE. The earliest next acceptance is E12, so back-to-back throughput is one conversion per 12 cycles.
- Outputs change only at the UPDATE edge; they never show intermediate digits.
- Reset asserted mid-conversion:
  - all outputs blank and `busy`/`done` clear asynchronously;
  - the interrupted request is discarded;
  - after deassertion the FSM starts in IDLE.
- Reset deassertion coincident with `load`=1: the load is accepted at the first clock edge at which `reset` is sampled high.

## Test plan
- Reset → all four outputs 7'b1111111, `busy`=0, `done`=0; assert reset during CONVERT → same values immediately, no later `done`.
- `load` with value=0 → after 11 edges: `OUT_H`=blank, `OUT_T`=blank, `OUT_O`=1000000, `OUT_N`=blank; `done` high exactly one cycle.
- value=−507 → `OUT_H`=0010010 (5), `OUT_T`=1000000 (0), `OUT_O`=1111000 (7), `OUT_N`=0111111. value=42 → `OUT_H` blank, `OUT_T`=0011001 (4), `OUT_O`=0100100 (2).
- value=999 → 9/9/9; value=1000 → E/r/r with `OUT_N` blank; value=−2^31 → E/r/r with `OUT_N`=minus.
- `load` pulses at E3 and E11 after an accepted load at E0 → both ignored; outputs reflect only the first value. A `load` at E12 is accepted, with `done` at E23.
- `value` changed every cycle during CONVERT → displayed result equals the value sampled at the accepting edge.
